// File: rtl/lu_cache_pkg.sv
// Shared LU cache constants and the dump FSM state type.
// Contents:
//   CELL_SIZE_DEF / CELL_COUNT_DEF / CELL_ADDR_SIZE_DEF : default cache geometry
//   CNT_WIDTH_DEF                                       : default update counter width
//   dump_state_e                                        : dump FSM states
package lu_cache_pkg;

  localparam int unsigned CELL_SIZE_DEF      = 8;
  localparam int unsigned CELL_COUNT_DEF     = 8;
  localparam int unsigned CELL_ADDR_SIZE_DEF = 3;
  localparam int unsigned CNT_WIDTH_DEF      = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } dump_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset (clears count)
//   inc   : increment enable for this cycle
//   count : current count (registered)
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  // Count enabled cycles, stop at the maximum value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (inc && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/lu_cache_dump.sv
// Snapshots the full LU cache contents on request and streams the cells out
// one per beat over valid/ready, with index and last flag. Also counts cache
// update strobes for debug readout.
// Ports:
//   clk, reset   : clock, asynchronous active-low reset
//   cache_data   : cache contents, index 0 = most recently used
//   new_data     : cache update strobe
//   dump_req     : start a dump (sampled in IDLE only)
//   busy         : dump in progress
//   out_data/out_idx/out_last/out_valid, out_ready : beat stream
//   update_cnt   : saturating count of new_data cycles
module lu_cache_dump
  import lu_cache_pkg::*;
#(
  parameter int unsigned CELL_SIZE      = CELL_SIZE_DEF,
  parameter int unsigned CELL_COUNT     = CELL_COUNT_DEF,
  parameter int unsigned CELL_ADDR_SIZE = CELL_ADDR_SIZE_DEF,
  parameter int unsigned CNT_WIDTH      = CNT_WIDTH_DEF
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [CELL_COUNT-1:0][CELL_SIZE-1:0]  cache_data,
  input  logic                                  new_data,
  input  logic                                  dump_req,
  output logic                                  busy,
  output logic [CELL_SIZE-1:0]                  out_data,
  output logic [CELL_ADDR_SIZE-1:0]             out_idx,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic                                  out_last,
  output logic [CNT_WIDTH-1:0]                  update_cnt
);

  localparam int unsigned LAST_IDX = CELL_COUNT - 1;

  dump_state_e                          r_state, w_state_next;
  logic [CELL_COUNT-1:0][CELL_SIZE-1:0] r_snap, w_snap_next;
  logic [CELL_ADDR_SIZE-1:0]            r_idx, w_idx_next;
  logic [CELL_SIZE-1:0]                 r_data, w_data_next;
  logic                                 r_last, w_last_next;
  logic                                 r_valid, r_busy;

  // State and output registers; beat fields hold their value outside SEND.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_snap  <= '0;
      r_idx   <= '0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_snap  <= w_snap_next;
      r_idx   <= w_idx_next;
      r_data  <= w_data_next;
      r_last  <= w_last_next;
      r_valid <= (w_state_next == SEND);
      r_busy  <= (w_state_next == SEND);
    end
  end

  // Next-state and next-beat logic. In SEND out_valid is always high, so
  // out_ready alone decides whether the current beat is accepted.
  always_comb begin
    w_state_next = r_state;
    w_snap_next  = r_snap;
    w_idx_next   = r_idx;
    w_data_next  = r_data;
    w_last_next  = r_last;
    case (r_state)
      IDLE: begin
        if (dump_req) begin
          w_state_next = SEND;
          w_snap_next  = cache_data;
          w_idx_next   = '0;
          w_data_next  = cache_data[0];
          w_last_next  = (LAST_IDX == 0);
        end
      end
      SEND: begin
        if (out_ready) begin
          if (r_idx == CELL_ADDR_SIZE'(LAST_IDX)) begin
            w_state_next = IDLE;
          end else begin
            w_idx_next  = r_idx + CELL_ADDR_SIZE'(1);
            w_data_next = r_snap[w_idx_next];
            w_last_next = (w_idx_next == CELL_ADDR_SIZE'(LAST_IDX));
          end
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign busy      = r_busy;
  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_idx   = r_idx;
  assign out_last  = r_last;

  // Update strobe statistics, independent of the dump FSM.
  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_update_cnt (
    .clk   (clk),
    .rst_n (reset),
    .inc   (new_data),
    .count (update_cnt)
  );

endmodule

// File: tb/tb_lu_cache_dump.sv
// Self-checking bench for lu_cache_dump: a fixed vector table for the basic
// dump, hand sequences for reset/backpressure/isolation/back-to-back/counter,
// and randomized traffic against a queue-based reference model.
module tb_lu_cache_dump;

  localparam int unsigned CS = 8;
  localparam int unsigned CC = 8;
  localparam int unsigned CA = 3;
  localparam int unsigned CW = 4;

  logic                   clk;
  logic                   reset;
  logic [CC-1:0][CS-1:0]  cache_data;
  logic                   new_data;
  logic                   dump_req;
  logic                   busy;
  logic [CS-1:0]          out_data;
  logic [CA-1:0]          out_idx;
  logic                   out_valid;
  logic                   out_ready;
  logic                   out_last;
  logic [CW-1:0]          update_cnt;

  lu_cache_dump #(
    .CELL_SIZE      (CS),
    .CELL_COUNT     (CC),
    .CELL_ADDR_SIZE (CA),
    .CNT_WIDTH      (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cache_data (cache_data),
    .new_data   (new_data),
    .dump_req   (dump_req),
    .busy       (busy),
    .out_data   (out_data),
    .out_idx    (out_idx),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .update_cnt (update_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a dump is a queue of pending beats; the front is on the bus.
  typedef struct {
    logic [CS-1:0] data;
    int            idx;
  } beat_t;

  beat_t q[$];
  beat_t last_beat;
  int    m_cnt;

  task automatic model_reset();
    q.delete();
    last_beat.data = '0;
    last_beat.idx  = 0;
    m_cnt          = 0;
  endtask

  task automatic model_edge();
    beat_t b;
    if (q.size() != 0) begin
      if (out_ready) last_beat = q.pop_front();
    end else if (dump_req) begin
      for (int i = 0; i < int'(CC); i++) begin
        b.data = cache_data[i];
        b.idx  = i;
        q.push_back(b);
      end
    end
    if (new_data && m_cnt < (2 ** CW) - 1) m_cnt++;
  endtask

  task automatic model_compare(input string tag);
    beat_t b;
    logic  ev;
    ev = (q.size() != 0);
    if (ev) b = q[0];
    else    b = last_beat;
    chk({tag, "_valid"}, 32'(out_valid), 32'(ev));
    chk({tag, "_busy"},  32'(busy),      32'(ev));
    chk({tag, "_data"},  32'(out_data),  32'(b.data));
    chk({tag, "_idx"},   32'(out_idx),   32'(b.idx));
    chk({tag, "_last"},  32'(out_last),  32'(b.idx == int'(CC) - 1));
    chk({tag, "_cnt"},   32'(update_cnt), 32'(m_cnt));
  endtask

  // One clock: model sees the same inputs the DUT samples, then compare.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    model_compare(tag);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Step until the model queue drains, bounded.
  task automatic drain(input string tag, input int max_cycles);
    int n;
    n = 0;
    while (q.size() != 0 && n < max_cycles) begin
      step(tag);
      n++;
    end
    if (q.size() != 0) chk({tag, "_timeout"}, 32'(1), 32'(0));
  endtask

  typedef struct {
    logic          dump_req;
    logic          out_ready;
    logic          new_data;
    logic          exp_valid;
    logic          exp_last;
    logic [CA-1:0] exp_idx;
    logic [CS-1:0] exp_data;
    logic [CW-1:0] exp_cnt;
  } vec_t;

  vec_t tbl[10];
  logic [CC-1:0][CS-1:0] ramp;
  logic [CC-1:0][CS-1:0] all_ff;
  logic [CC-1:0][CS-1:0] all_a5;
  logic                  bp_pat[5];

  initial begin
    for (int i = 0; i < int'(CC); i++) begin
      ramp[i]   = CS'(i * 17);
      all_ff[i] = 8'hFF;
      all_a5[i] = 8'hA5;
    end
    bp_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    // Basic dump table: pulse at step 0, ready high, new_data on steps 0..2.
    for (int k = 0; k < 8; k++) begin
      tbl[k].dump_req  = (k == 0);
      tbl[k].out_ready = 1'b1;
      tbl[k].new_data  = (k < 3);
      tbl[k].exp_valid = 1'b1;
      tbl[k].exp_last  = (k == 7);
      tbl[k].exp_idx   = CA'(k);
      tbl[k].exp_data  = CS'(k * 17);
      tbl[k].exp_cnt   = (k < 3) ? CW'(k + 1) : CW'(3);
    end
    for (int k = 8; k < 10; k++) begin
      tbl[k].dump_req  = 1'b0;
      tbl[k].out_ready = (k == 8);
      tbl[k].new_data  = 1'b0;
      tbl[k].exp_valid = 1'b0;
      tbl[k].exp_last  = 1'b1;
      tbl[k].exp_idx   = CA'(7);
      tbl[k].exp_data  = 8'h77;
      tbl[k].exp_cnt   = CW'(3);
    end

    reset      = 1'b0;
    cache_data = ramp;
    new_data   = 1'b0;
    dump_req   = 1'b0;
    out_ready  = 1'b0;
    model_reset();
    #1;
    chk("rst_busy",  32'(busy),       32'(0));
    chk("rst_valid", 32'(out_valid),  32'(0));
    chk("rst_data",  32'(out_data),   32'(0));
    chk("rst_idx",   32'(out_idx),    32'(0));
    chk("rst_last",  32'(out_last),   32'(0));
    chk("rst_cnt",   32'(update_cnt), 32'(0));
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Table-driven basic dump.
    for (int k = 0; k < 10; k++) begin
      dump_req  = tbl[k].dump_req;
      out_ready = tbl[k].out_ready;
      new_data  = tbl[k].new_data;
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_valid", k), 32'(out_valid),  32'(tbl[k].exp_valid));
      chk($sformatf("tbl%0d_busy", k),  32'(busy),       32'(tbl[k].exp_valid));
      chk($sformatf("tbl%0d_idx", k),   32'(out_idx),    32'(tbl[k].exp_idx));
      chk($sformatf("tbl%0d_data", k),  32'(out_data),   32'(tbl[k].exp_data));
      chk($sformatf("tbl%0d_last", k),  32'(out_last),   32'(tbl[k].exp_last));
      chk($sformatf("tbl%0d_cnt", k),   32'(update_cnt), 32'(tbl[k].exp_cnt));
    end

    // Asynchronous reset in the middle of a dump, between clock edges.
    dump_req  = 1'b1;
    out_ready = 1'b1;
    new_data  = 1'b1;
    @(posedge clk);
    #1;
    dump_req = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    #2;
    reset = 1'b0;
    #1;
    chk("arst_busy",  32'(busy),       32'(0));
    chk("arst_valid", 32'(out_valid),  32'(0));
    chk("arst_data",  32'(out_data),   32'(0));
    chk("arst_idx",   32'(out_idx),    32'(0));
    chk("arst_last",  32'(out_last),   32'(0));
    chk("arst_cnt",   32'(update_cnt), 32'(0));
    new_data = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Backpressure: ready pattern 1,0,0,1,0 repeating; count DUT handshakes.
    begin
      int n;
      int xfers;
      logic [CS-1:0] hold_d;
      logic [CA-1:0] hold_i;
      logic          stalled;
      cache_data = ramp;
      dump_req   = 1'b1;
      out_ready  = 1'b0;
      step("bp_start");
      dump_req = 1'b0;
      n = 0;
      xfers = 0;
      while (out_valid && n < 100) begin
        out_ready = bp_pat[n % 5];
        stalled   = !out_ready;
        hold_d    = out_data;
        hold_i    = out_idx;
        if (out_ready) xfers++;
        step("bp");
        if (stalled) begin
          chk("bp_hold_data", 32'(out_data), 32'(hold_d));
          chk("bp_hold_idx",  32'(out_idx),  32'(hold_i));
        end
        n++;
      end
      if (n >= 100) chk("bp_timeout", 32'(1), 32'(0));
      chk("bp_xfers", 32'(xfers), 32'(8));
    end

    // Snapshot isolation and a request while busy.
    out_ready  = 1'b1;
    cache_data = ramp;
    dump_req   = 1'b1;
    step("iso_start");
    dump_req = 1'b0;
    step("iso_b1");
    cache_data = all_ff;
    dump_req   = 1'b1;
    step("iso_req");
    chk("iso_snap_data", 32'(out_data), 32'(8'h22));
    dump_req = 1'b0;
    drain("iso", 20);
    repeat (3) step("iso_idle");
    chk("iso_no_second", 32'(out_valid), 32'(0));

    // Back-to-back: request in the cycle right after the last accept.
    cache_data = ramp;
    dump_req   = 1'b1;
    step("b2b_first");
    dump_req = 1'b0;
    drain("b2b_a", 20);
    cache_data = all_a5;
    dump_req   = 1'b1;
    step("b2b_req");
    chk("b2b_first_valid", 32'(out_valid), 32'(1));
    chk("b2b_first_data",  32'(out_data),  32'(8'hA5));
    dump_req = 1'b0;
    drain("b2b_b", 20);

    // Counter saturation across a dump.
    do_reset();
    cache_data = ramp;
    new_data   = 1'b1;
    for (int k = 0; k < 20; k++) begin
      dump_req = (k == 5);
      step("cnt");
    end
    new_data = 1'b0;
    chk("cnt_sat", 32'(update_cnt), 32'(15));
    step("cnt_hold");
    chk("cnt_hold15", 32'(update_cnt), 32'(15));

    // Randomized traffic against the model.
    do_reset();
    for (int k = 0; k < 400; k++) begin
      dump_req  = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      new_data  = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0) begin
        for (int i = 0; i < int'(CC); i++) cache_data[i] = CS'($urandom);
      end
      step("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
